// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset sequencer with lock timeout retry and system reset gating
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4800,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       rst_sys,
  output logic       sys_ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic [1:0]      sync_q;
  logic            lk;
  logic            pll_rst_q, rst_sys_q, sys_ready_q, fail_q;

  assign lk = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_PLL_RESET: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes precedence over the retry
        if (lk) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
          state_d = (retry_q == 4'(MAX_RETRIES)) ? S_FAIL : S_PLL_RESET;
        end
      end
      S_STABILIZE: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lk) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          loss_d  = (loss_q == 8'hff) ? loss_q : loss_q + 8'd1;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      rst_sys_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync_q      <= {sync_q[0], pll_locked};
      // Outputs are decoded from the next state so they line up with state_q
      pll_rst_q   <= (state_d == S_PLL_RESET);
      rst_sys_q   <= (state_d != S_RUN);
      sys_ready_q <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_sys     = rst_sys_q;
  assign sys_ready   = sys_ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule
